tdm_demux_1_to_4: RTL and testbench
===================================

# tdm_demux_1_to_4

Time-division demultiplexer: the receive-side counterpart of the team's 4-to-1 channel multiplexers. It accepts a stream of W-bit samples carrying four channels in round-robin slot order, marked by a start-of-frame flag. It rebuilds the four channels into a parallel registered bus and flags framing errors. It sits at the far end of a serialised 4-channel link, feeding parallel consumers.

## Interface
- W, default 1: width of one channel sample in bits.

- CLK  input  1  rising-edge clock; only clock.
- RST  input  1  synchronous, active-high reset; sampled on CLK rising edge.
- D  input  W  incoming sample for the current slot.
- VALID  input  1  D/SOF qualifier; a sample is consumed on every CLK edge with VALID=1.
- SOF  input  1  start of frame; marks the slot-0 sample and is ignored when VALID=0.
- OUT  output  4*W  reconstructed frame; channel k at OUT[k*W +: W].
- OUT_VALID  output  1  one-cycle pulse: OUT was updated with a complete frame this cycle.
- SEL  output  2  slot index expected for the next consumed sample.
- LOCKED  output  1  high while frame-aligned.
- ERR  output  1  one-cycle pulse on framing error.

## Operation
- Two states: HUNT and LOCK. The reset state is HUNT.
- Internal shadow registers S0..S2 (each W bits) hold the slots 0-2 of the frame in progress.
- **HUNT:**
  - Consumed samples with SOF=0 are discarded silently, with no ERR.
  - A consumed sample with SOF=1 writes S0 and sets SEL to 1. The next state is LOCK.
- **LOCK,** on each consumed sample:
  - SOF=1 and SEL=0: normal slot 0. Writes S0 and sets SEL to 1.
  - SOF=1 and SEL≠0 (early SOF): ERR pulses and the partial frame is dropped. The sample is taken as slot 0 (writes S0, SEL to 1). The state stays LOCK; this is a resync.
  - SOF=0 and SEL=0 (missing SOF): ERR pulses, SEL goes to 0 and the next state is HUNT. The sample is discarded.
  - SOF=0 and SEL=1 or 2: writes S[SEL] and increments SEL.
  - SOF=0 and SEL=3: OUT loads {D, S2, S1, S0}, OUT_VALID pulses and SEL goes to 0.
- A sample with SOF=1 arriving at slot 3 is treated as an early SOF. It never completes a frame.
- VALID=0 cycles are gaps:
  - All state, SEL and OUT are held.
  - No timeout.
  - OUT_VALID and ERR are 0.
- OUT is held between frames. It changes only on a completed frame or on reset.
- LOCKED = (state == LOCK).
- No backpressure. The block consumes one sample per cycle indefinitely.

## Timing
- All outputs are registered. None has a combinational path from an input.
- Frame latency:
  - OUT and OUT_VALID update on the CLK edge that consumes the slot-3 sample. They are visible in the following cycle.
  - Latency is 1 cycle from the last sample, and 4 cycles minimum from the slot-0 sample with back-to-back VALID.
- ERR is asserted in the cycle after the offending sample is consumed, for exactly one cycle.
- SEL and LOCKED reflect the state after each edge.
- Throughput: one frame per 4 consecutive VALID cycles. Back-to-back frames produce OUT_VALID every 4th cycle.
- RST=1 at a clock edge forces the following, overriding any simultaneous sample:
  - OUT=0, OUT_VALID=0, SEL=0, LOCKED=0, ERR=0.
  - S0..S2 cleared.
  - State HUNT.
- Reset mid-frame drops the partial frame. OUT_VALID is never produced for it.

## Test plan
- **Reset:** W=4, hold RST 2 cycles with random D/VALID/SOF. Required: OUT=0x0000, OUT_VALID=0, SEL=0, LOCKED=0, ERR=0.
- **Nominal frames:**
  - Stimulus: back-to-back VALID samples 0x1(SOF),0x2,0x3,0x4, then 0x5(SOF),0x6,0x7,0x8.
  - Required: OUT=0x4321 with a single OUT_VALID pulse, then OUT=0x8765 exactly 4 cycles later. LOCKED=1 from the cycle after the first SOF. ERR never asserts.
- **Gaps:**
  - Stimulus: frame 0xA(SOF),0xB,0xC,0xD with VALID=0 for 3 cycles between each sample.
  - Required: OUT=0xDCBA, OUT_VALID one cycle after 0xD. SEL steps 1,2,3,0 and holds during gaps.
- **Early SOF resync:**
  - Stimulus: 0x1(SOF),0x2, then 0x9(SOF),0x8,0x7,0x6.
  - Required: ERR pulse after 0x9 with LOCKED staying 1. OUT=0x6789 with no OUT_VALID for the dropped frame.
- **Missing SOF:**
  - Stimulus: after a complete frame, samples 0x3,0x4 with SOF=0, then 0x1(SOF),0x2,0x3,0x4.
  - Required: one ERR pulse and LOCKED=0 after 0x3. 0x4 is discarded without ERR. Relock, then OUT=0x4321.
- **Reset mid-frame:**
  - Stimulus: 0x1(SOF),0x2, then RST for 1 cycle, then 0x3,0x4 (no SOF).
  - Required: no OUT_VALID, OUT stays 0x0000, state HUNT, and no ERR for the 0x3/0x4 samples.

Source files
------------

// File: rtl/tdm_demux_1_to_4.sv
// Receive-side TDM demultiplexer: rebuilds four round-robin channel slots, framed by SOF,
// into a registered parallel bus and reports framing errors.
module tdm_demux_1_to_4 #(
    parameter int unsigned W = 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [W-1:0]   D,
    input  logic           VALID,
    input  logic           SOF,
    output logic [4*W-1:0] OUT,
    output logic           OUT_VALID,
    output logic [1:0]     SEL,
    output logic           LOCKED,
    output logic           ERR
);

    typedef enum logic {StHunt, StLock} state_e;

    state_e       state_q;
    logic [W-1:0] s0_q, s1_q, s2_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StHunt;
            s0_q      <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            OUT       <= '0;
            OUT_VALID <= 1'b0;
            SEL       <= 2'd0;
            LOCKED    <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            OUT_VALID <= 1'b0;
            ERR       <= 1'b0;
            if (VALID) begin
                unique case (state_q)
                    StHunt: begin
                        if (SOF) begin
                            s0_q    <= D;
                            SEL     <= 2'd1;
                            state_q <= StLock;
                            LOCKED  <= 1'b1;
                        end
                    end
                    StLock: begin
                        if (SOF) begin
                            // SOF mid-frame drops the partial frame and restarts at slot 0
                            ERR  <= (SEL != 2'd0);
                            s0_q <= D;
                            SEL  <= 2'd1;
                        end else begin
                            unique case (SEL)
                                2'd0: begin
                                    ERR     <= 1'b1;
                                    state_q <= StHunt;
                                    LOCKED  <= 1'b0;
                                end
                                2'd1: begin
                                    s1_q <= D;
                                    SEL  <= 2'd2;
                                end
                                2'd2: begin
                                    s2_q <= D;
                                    SEL  <= 2'd3;
                                end
                                2'd3: begin
                                    OUT       <= {D, s2_q, s1_q, s0_q};
                                    OUT_VALID <= 1'b1;
                                    SEL       <= 2'd0;
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// Directed bench for tdm_demux_1_to_4 (W=4): each scenario steps a table of samples and
// compares every output against hand-computed values one time unit after the clock edge.
module tb_tdm_demux_1_to_4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  D = '0;
    logic        VALID = 1'b0;
    logic        SOF = 1'b0;
    logic [15:0] OUT;
    logic        OUT_VALID;
    logic [1:0]  SEL;
    logic        LOCKED;
    logic        ERR;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        v;
        logic        sof;
        logic [3:0]  d;
        logic [1:0]  sel;
        logic        lock;
        logic        err;
        logic        ov;
        logic [15:0] out;
    } step_t;

    tdm_demux_1_to_4 #(.W(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .D         (D),
        .VALID     (VALID),
        .SOF       (SOF),
        .OUT       (OUT),
        .OUT_VALID (OUT_VALID),
        .SEL       (SEL),
        .LOCKED    (LOCKED),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic r, input logic v, input logic s, input logic [3:0] d);
        RST = r; VALID = v; SOF = s; D = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom_range(15)));
            checks++; if (OUT !== 16'h0000) begin errors++; $display("FAIL reset OUT got %h exp 0000", OUT); end
            checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset OUT_VALID got %b exp 0", OUT_VALID); end
            checks++; if (SEL !== 2'd0) begin errors++; $display("FAIL reset SEL got %0d exp 0", SEL); end
            checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL reset LOCKED got %b exp 0", LOCKED); end
            checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset ERR got %b exp 0", ERR); end
        end
    endtask

    task automatic test_nominal();
        step_t t[9] = '{
            '{0,1,1,4'h1,2'd1,1,0,0,16'h0000}, '{0,1,0,4'h2,2'd2,1,0,0,16'h0000},
            '{0,1,0,4'h3,2'd3,1,0,0,16'h0000}, '{0,1,0,4'h4,2'd0,1,0,1,16'h4321},
            '{0,1,1,4'h5,2'd1,1,0,0,16'h4321}, '{0,1,0,4'h6,2'd2,1,0,0,16'h4321},
            '{0,1,0,4'h7,2'd3,1,0,0,16'h4321}, '{0,1,0,4'h8,2'd0,1,0,1,16'h8765},
            '{0,0,0,4'h0,2'd0,1,0,0,16'h8765}};
        for (int i = 0; i < 9; i++) begin
            drive(t[i].rst, t[i].v, t[i].sof, t[i].d);
            checks++; if (OUT !== t[i].out) begin errors++; $display("FAIL nominal[%0d] OUT got %h exp %h", i, OUT, t[i].out); end
            checks++; if (OUT_VALID !== t[i].ov) begin errors++; $display("FAIL nominal[%0d] OUT_VALID got %b exp %b", i, OUT_VALID, t[i].ov); end
            checks++; if (SEL !== t[i].sel) begin errors++; $display("FAIL nominal[%0d] SEL got %0d exp %0d", i, SEL, t[i].sel); end
            checks++; if (LOCKED !== t[i].lock) begin errors++; $display("FAIL nominal[%0d] LOCKED got %b exp %b", i, LOCKED, t[i].lock); end
            checks++; if (ERR !== t[i].err) begin errors++; $display("FAIL nominal[%0d] ERR got %b exp %b", i, ERR, t[i].err); end
        end
    endtask

    task automatic test_gaps();
        step_t t[14];
        logic [3:0] smp[4] = '{4'hA, 4'hB, 4'hC, 4'hD};
        logic [1:0] sel_after[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < 4; g++) begin
                if (k * 4 + g < 14) begin
                    t[k*4+g] = '{0, (g == 0), (k == 0 && g == 0), (g == 0) ? smp[k] : 4'h0,
                                 sel_after[k], 1, 0, (k == 3 && g == 0),
                                 (k == 3) ? 16'hDCBA : 16'h8765};
                end
            end
        end
        for (int i = 0; i < 14; i++) begin
            drive(t[i].rst, t[i].v, t[i].sof, t[i].d);
            checks++; if (OUT !== t[i].out) begin errors++; $display("FAIL gaps[%0d] OUT got %h exp %h", i, OUT, t[i].out); end
            checks++; if (OUT_VALID !== t[i].ov) begin errors++; $display("FAIL gaps[%0d] OUT_VALID got %b exp %b", i, OUT_VALID, t[i].ov); end
            checks++; if (SEL !== t[i].sel) begin errors++; $display("FAIL gaps[%0d] SEL got %0d exp %0d", i, SEL, t[i].sel); end
            checks++; if (LOCKED !== t[i].lock) begin errors++; $display("FAIL gaps[%0d] LOCKED got %b exp %b", i, LOCKED, t[i].lock); end
            checks++; if (ERR !== t[i].err) begin errors++; $display("FAIL gaps[%0d] ERR got %b exp %b", i, ERR, t[i].err); end
        end
    endtask

    task automatic test_early_sof();
        step_t t[6] = '{
            '{0,1,1,4'h1,2'd1,1,0,0,16'hDCBA}, '{0,1,0,4'h2,2'd2,1,0,0,16'hDCBA},
            '{0,1,1,4'h9,2'd1,1,1,0,16'hDCBA}, '{0,1,0,4'h8,2'd2,1,0,0,16'hDCBA},
            '{0,1,0,4'h7,2'd3,1,0,0,16'hDCBA}, '{0,1,0,4'h6,2'd0,1,0,1,16'h6789}};
        for (int i = 0; i < 6; i++) begin
            drive(t[i].rst, t[i].v, t[i].sof, t[i].d);
            checks++; if (OUT !== t[i].out) begin errors++; $display("FAIL early_sof[%0d] OUT got %h exp %h", i, OUT, t[i].out); end
            checks++; if (OUT_VALID !== t[i].ov) begin errors++; $display("FAIL early_sof[%0d] OUT_VALID got %b exp %b", i, OUT_VALID, t[i].ov); end
            checks++; if (SEL !== t[i].sel) begin errors++; $display("FAIL early_sof[%0d] SEL got %0d exp %0d", i, SEL, t[i].sel); end
            checks++; if (LOCKED !== t[i].lock) begin errors++; $display("FAIL early_sof[%0d] LOCKED got %b exp %b", i, LOCKED, t[i].lock); end
            checks++; if (ERR !== t[i].err) begin errors++; $display("FAIL early_sof[%0d] ERR got %b exp %b", i, ERR, t[i].err); end
        end
    endtask

    task automatic test_missing_sof();
        step_t t[10] = '{
            '{0,1,1,4'hE,2'd1,1,0,0,16'h6789}, '{0,1,0,4'hF,2'd2,1,0,0,16'h6789},
            '{0,1,0,4'h0,2'd3,1,0,0,16'h6789}, '{0,1,0,4'h1,2'd0,1,0,1,16'h10FE},
            '{0,1,0,4'h3,2'd0,0,1,0,16'h10FE}, '{0,1,0,4'h4,2'd0,0,0,0,16'h10FE},
            '{0,1,1,4'h1,2'd1,1,0,0,16'h10FE}, '{0,1,0,4'h2,2'd2,1,0,0,16'h10FE},
            '{0,1,0,4'h3,2'd3,1,0,0,16'h10FE}, '{0,1,0,4'h4,2'd0,1,0,1,16'h4321}};
        for (int i = 0; i < 10; i++) begin
            drive(t[i].rst, t[i].v, t[i].sof, t[i].d);
            checks++; if (OUT !== t[i].out) begin errors++; $display("FAIL missing_sof[%0d] OUT got %h exp %h", i, OUT, t[i].out); end
            checks++; if (OUT_VALID !== t[i].ov) begin errors++; $display("FAIL missing_sof[%0d] OUT_VALID got %b exp %b", i, OUT_VALID, t[i].ov); end
            checks++; if (SEL !== t[i].sel) begin errors++; $display("FAIL missing_sof[%0d] SEL got %0d exp %0d", i, SEL, t[i].sel); end
            checks++; if (LOCKED !== t[i].lock) begin errors++; $display("FAIL missing_sof[%0d] LOCKED got %b exp %b", i, LOCKED, t[i].lock); end
            checks++; if (ERR !== t[i].err) begin errors++; $display("FAIL missing_sof[%0d] ERR got %b exp %b", i, ERR, t[i].err); end
        end
    endtask

    task automatic test_reset_mid_frame();
        // The reset cycle also carries a VALID SOF sample that reset must override
        step_t t[5] = '{
            '{0,1,1,4'h1,2'd1,1,0,0,16'h4321}, '{0,1,0,4'h2,2'd2,1,0,0,16'h4321},
            '{1,1,1,4'h3,2'd0,0,0,0,16'h0000}, '{0,1,0,4'h3,2'd0,0,0,0,16'h0000},
            '{0,1,0,4'h4,2'd0,0,0,0,16'h0000}};
        for (int i = 0; i < 5; i++) begin
            drive(t[i].rst, t[i].v, t[i].sof, t[i].d);
            checks++; if (OUT !== t[i].out) begin errors++; $display("FAIL reset_mid[%0d] OUT got %h exp %h", i, OUT, t[i].out); end
            checks++; if (OUT_VALID !== t[i].ov) begin errors++; $display("FAIL reset_mid[%0d] OUT_VALID got %b exp %b", i, OUT_VALID, t[i].ov); end
            checks++; if (SEL !== t[i].sel) begin errors++; $display("FAIL reset_mid[%0d] SEL got %0d exp %0d", i, SEL, t[i].sel); end
            checks++; if (LOCKED !== t[i].lock) begin errors++; $display("FAIL reset_mid[%0d] LOCKED got %b exp %b", i, LOCKED, t[i].lock); end
            checks++; if (ERR !== t[i].err) begin errors++; $display("FAIL reset_mid[%0d] ERR got %b exp %b", i, ERR, t[i].err); end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_gaps();
        test_early_sof();
        test_missing_sof();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
